// File: rtl/warp_xissue.sv
// Scalar integer issue / operand-fetch stage: scoreboard hazard check, xrf read, writeback bypass.
// Optional WARP_XISSUE_STALL_CNT_EN adds a saturating o_stall_cnt of decode-stall cycles.
module warp_xissue #(
  parameter int XLEN   = 64,
  parameter int CTRL_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_dec_valid,
  output logic              o_dec_ready,
  input  logic [4:0]        i_dec_rs1,
  input  logic [4:0]        i_dec_rs2,
  input  logic [4:0]        i_dec_rd,
  input  logic              i_dec_rd_wen,
  input  logic [CTRL_W-1:0] i_dec_ctrl,
  output logic [4:0]        o_rs1_addr,
  output logic [4:0]        o_rs2_addr,
  input  logic [XLEN-1:0]   i_rs1_rdata,
  input  logic [XLEN-1:0]   i_rs2_rdata,
  input  logic              i_wb1_valid,
  input  logic              i_wb2_valid,
  input  logic [4:0]        i_wb1_addr,
  input  logic [4:0]        i_wb2_addr,
  input  logic [XLEN-1:0]   i_wb1_data,
  input  logic [XLEN-1:0]   i_wb2_data,
  output logic              o_ex_valid,
  input  logic              i_ex_ready,
  output logic [XLEN-1:0]   o_ex_op1,
  output logic [XLEN-1:0]   o_ex_op2,
  output logic [4:0]        o_ex_rd,
  output logic              o_ex_rd_wen,
  output logic [CTRL_W-1:0] o_ex_ctrl
`ifdef WARP_XISSUE_STALL_CNT_EN
  ,
  output logic [31:0]       o_stall_cnt
`endif
);

  // Bit 0 exists only so any 5-bit address can index directly; it is held at 0.
  logic [31:0]       busy_q, busy_d;
  logic              ex_valid_q, ex_valid_d;
  logic [4:0]        rd_q, rs1_q, rs2_q;
  logic              rd_wen_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic              byp1_q, byp1_d, byp2_q, byp2_d;
  logic [XLEN-1:0]   byp1_data_q, byp1_data_d, byp2_data_q, byp2_data_d;
  logic              s1_free, stall_hold, accept;
  logic              src1_ok, src2_ok, waw_ok;

  function automatic logic wb_hit(input logic v, input logic [4:0] a, input logic [4:0] r);
    return v && (a == r) && (r != 5'd0);
  endfunction

  assign s1_free    = !ex_valid_q || i_ex_ready;
  assign stall_hold = ex_valid_q && !i_ex_ready;

  assign src1_ok = (i_dec_rs1 == 5'd0) || !busy_q[i_dec_rs1] ||
                   wb_hit(i_wb1_valid, i_wb1_addr, i_dec_rs1) ||
                   wb_hit(i_wb2_valid, i_wb2_addr, i_dec_rs1);
  assign src2_ok = (i_dec_rs2 == 5'd0) || !busy_q[i_dec_rs2] ||
                   wb_hit(i_wb1_valid, i_wb1_addr, i_dec_rs2) ||
                   wb_hit(i_wb2_valid, i_wb2_addr, i_dec_rs2);
  assign waw_ok  = !i_dec_rd_wen || (i_dec_rd == 5'd0) || !busy_q[i_dec_rd];

  assign o_dec_ready = s1_free && src1_ok && src2_ok && waw_ok;
  assign accept      = i_dec_valid && o_dec_ready;

  // x0 is folded into the bypass path: flag set with zero data.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path infers a latch.
    byp1_d      = 1'b1;
    byp1_data_d = '0;
    byp2_d      = 1'b1;
    byp2_data_d = '0;
    if (wb_hit(i_wb1_valid, i_wb1_addr, i_dec_rs1))      byp1_data_d = i_wb1_data;
    else if (wb_hit(i_wb2_valid, i_wb2_addr, i_dec_rs1)) byp1_data_d = i_wb2_data;
    else                                                 byp1_d      = (i_dec_rs1 == 5'd0);
    if (wb_hit(i_wb1_valid, i_wb1_addr, i_dec_rs2))      byp2_data_d = i_wb1_data;
    else if (wb_hit(i_wb2_valid, i_wb2_addr, i_dec_rs2)) byp2_data_d = i_wb2_data;
    else                                                 byp2_d      = (i_dec_rs2 == 5'd0);
  end

  // Clears first, then the set, so a same-cycle set of the same bit wins.
  always_comb begin
    busy_d = busy_q;
    if (i_wb1_valid) busy_d[i_wb1_addr] = 1'b0;
    if (i_wb2_valid) busy_d[i_wb2_addr] = 1'b0;
    if (accept && i_dec_rd_wen) busy_d[i_dec_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  assign ex_valid_d = accept || stall_hold;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q     <= '0;
      ex_valid_q <= 1'b0;
      rd_q       <= '0;
      rd_wen_q   <= 1'b0;
      ctrl_q     <= '0;
      byp1_q     <= 1'b0;
      byp2_q     <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      ex_valid_q <= ex_valid_d;
      if (accept) begin
        rd_q     <= i_dec_rd;
        rd_wen_q <= i_dec_rd_wen;
        ctrl_q   <= i_dec_ctrl;
        byp1_q   <= byp1_d;
        byp2_q   <= byp2_d;
      end
    end
  end

  // NOTE: datapath payload is deliberately left unreset; ex_valid and the bypass flags qualify it.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      rs1_q       <= i_dec_rs1;
      rs2_q       <= i_dec_rs2;
      byp1_data_q <= byp1_data_d;
      byp2_data_q <= byp2_data_d;
    end
  end

  // During a stall the xrf keeps re-reading the held sources so its registered data stays valid.
  assign o_rs1_addr  = stall_hold ? rs1_q : i_dec_rs1;
  assign o_rs2_addr  = stall_hold ? rs2_q : i_dec_rs2;
  assign o_ex_valid  = ex_valid_q;
  assign o_ex_op1    = byp1_q ? byp1_data_q : i_rs1_rdata;
  assign o_ex_op2    = byp2_q ? byp2_data_q : i_rs2_rdata;
  assign o_ex_rd     = rd_q;
  assign o_ex_rd_wen = rd_wen_q;
  assign o_ex_ctrl   = ctrl_q;

`ifdef WARP_XISSUE_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
    end else if (i_dec_valid && !o_dec_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_warp_xissue.sv
// Self-checking bench for warp_xissue: directed scenarios plus randomized traffic against a
// register-level reference model (architectural xrf, busy set, pending-writeback queue).
module tb_warp_xissue;
  localparam int XLEN   = 64;
  localparam int CTRL_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              dec_valid, dec_ready, dec_rd_wen, ex_valid, ex_ready, ex_rd_wen;
  logic [4:0]        dec_rs1, dec_rs2, dec_rd, rs1_addr, rs2_addr, ex_rd;
  logic [CTRL_W-1:0] dec_ctrl, ex_ctrl;
  logic [XLEN-1:0]   rs1_rdata, rs2_rdata, ex_op1, ex_op2;
  logic              wb1_valid, wb2_valid;
  logic [4:0]        wb1_addr, wb2_addr;
  logic [XLEN-1:0]   wb1_data, wb2_data;
`ifdef WARP_XISSUE_STALL_CNT_EN
  logic [31:0]       stall_cnt;
`endif

  warp_xissue #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_dec_valid(dec_valid), .o_dec_ready(dec_ready),
    .i_dec_rs1(dec_rs1), .i_dec_rs2(dec_rs2), .i_dec_rd(dec_rd),
    .i_dec_rd_wen(dec_rd_wen), .i_dec_ctrl(dec_ctrl),
    .o_rs1_addr(rs1_addr), .o_rs2_addr(rs2_addr),
    .i_rs1_rdata(rs1_rdata), .i_rs2_rdata(rs2_rdata),
    .i_wb1_valid(wb1_valid), .i_wb2_valid(wb2_valid),
    .i_wb1_addr(wb1_addr), .i_wb2_addr(wb2_addr),
    .i_wb1_data(wb1_data), .i_wb2_data(wb2_data),
    .o_ex_valid(ex_valid), .i_ex_ready(ex_ready),
    .o_ex_op1(ex_op1), .o_ex_op2(ex_op2),
    .o_ex_rd(ex_rd), .o_ex_rd_wen(ex_rd_wen), .o_ex_ctrl(ex_ctrl)
`ifdef WARP_XISSUE_STALL_CNT_EN
    , .o_stall_cnt(stall_cnt)
`endif
  );

  // Register file with a registered read port; wb1 is written last so it wins on equal addresses.
  logic [XLEN-1:0] xrf [32];

  function automatic logic [XLEN-1:0] init_val(input int i);
    if (i == 0) return '0;
    if (i == 3) return 64'd5;
    if (i == 4) return 64'd7;
    return 64'h1000_0000_0000_0000 | (64'(i) * 64'h0101);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) xrf[i] <= init_val(i);
    end else begin
      if (wb2_valid && wb2_addr != 5'd0) xrf[wb2_addr] <= wb2_data;
      if (wb1_valid && wb1_addr != 5'd0) xrf[wb1_addr] <= wb1_data;
    end
    rs1_rdata <= xrf[rs1_addr];
    rs2_rdata <= xrf[rs2_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: what execute should currently see, plus which registers have a writer in flight.
  bit                busy_m [32];
  bit                m_valid;
  logic [XLEN-1:0]   m_op1, m_op2;
  logic [4:0]        m_rd, m_rs1, m_rs2;
  logic              m_wen;
  logic [CTRL_W-1:0] m_ctrl;
  int unsigned       m_cnt;
  logic [4:0]        pend [$];
  logic              exp_ready;

  function automatic bit wb_writes(input logic [4:0] r);
    return r != 5'd0 && ((wb1_valid && wb1_addr == r) || (wb2_valid && wb2_addr == r));
  endfunction

  function automatic bit src_ok(input logic [4:0] r);
    return r == 5'd0 || !busy_m[r] || wb_writes(r);
  endfunction

  function automatic logic [XLEN-1:0] operand(input logic [4:0] r);
    if (r == 5'd0) return '0;
    if (wb1_valid && wb1_addr == r) return wb1_data;
    if (wb2_valid && wb2_addr == r) return wb2_data;
    return xrf[r];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
    m_valid = 1'b0;
    m_cnt   = 0;
    pend.delete();
  endtask

  task automatic idle();
    dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0; dec_rd_wen = 1'b0; dec_ctrl = '0;
    wb1_valid = 1'b0; wb1_addr = '0; wb1_data = '0;
    wb2_valid = 1'b0; wb2_addr = '0; wb2_data = '0;
    ex_ready  = 1'b1;
  endtask

  task automatic take(input logic [4:0] r);
    for (int i = 0; i < pend.size(); i++)
      if (pend[i] == r) begin
        pend.delete(i);
        return;
      end
  endtask

  task automatic drive_wbs();
    if (pend.size() > 0 && $urandom_range(2) != 0) begin
      wb1_valid = 1'b1; wb1_addr = pend.pop_front(); wb1_data = {$urandom, $urandom};
    end else if ($urandom_range(7) == 0) begin
      wb1_valid = 1'b1; wb1_addr = 5'd0; wb1_data = {$urandom, $urandom};
    end
    if (pend.size() > 0 && $urandom_range(2) != 0) begin
      wb2_valid = 1'b1; wb2_addr = pend.pop_front(); wb2_data = {$urandom, $urandom};
    end
  endtask

  // Called just after a falling edge with inputs applied; checks, then advances one cycle.
  task automatic step();
    bit accept, retire;
    #1;
    exp_ready = (!m_valid || ex_ready) && src_ok(dec_rs1) && src_ok(dec_rs2) &&
                (!dec_rd_wen || dec_rd == 5'd0 || !busy_m[dec_rd]);
    check("dec_ready", dec_ready, exp_ready);
    check("rs1_addr", rs1_addr, (m_valid && !ex_ready) ? m_rs1 : dec_rs1);
    check("rs2_addr", rs2_addr, (m_valid && !ex_ready) ? m_rs2 : dec_rs2);
    check("ex_valid", ex_valid, m_valid);
    if (m_valid) begin
      check("ex_op1", ex_op1, m_op1);
      check("ex_op2", ex_op2, m_op2);
      check("ex_rd", ex_rd, m_rd);
      check("ex_rd_wen", ex_rd_wen, m_wen);
      check("ex_ctrl", ex_ctrl, m_ctrl);
    end
`ifdef WARP_XISSUE_STALL_CNT_EN
    check("stall_cnt", stall_cnt, m_cnt);
`endif
    accept = dec_valid && exp_ready;
    retire = m_valid && ex_ready;
    if (dec_valid && !exp_ready && m_cnt != 32'hFFFF_FFFF) m_cnt++;
    @(posedge clk);
    if (retire && m_wen && m_rd != 5'd0) pend.push_back(m_rd);
    if (wb1_valid) busy_m[wb1_addr] = 1'b0;
    if (wb2_valid) busy_m[wb2_addr] = 1'b0;
    if (accept) begin
      m_valid = 1'b1;
      m_op1 = operand(dec_rs1); m_op2 = operand(dec_rs2);
      m_rs1 = dec_rs1; m_rs2 = dec_rs2; m_rd = dec_rd; m_wen = dec_rd_wen; m_ctrl = dec_ctrl;
      if (dec_rd_wen && dec_rd != 5'd0) busy_m[dec_rd] = 1'b1;
    end else if (ex_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic wen);
    dec_valid = 1'b1; dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd; dec_rd_wen = wen;
    dec_ctrl = 16'($urandom);
  endtask

  task automatic drain();
    for (int c = 0; c < 40; c++) begin
      idle();
      drive_wbs();
      step();
      if (pend.size() == 0 && !m_valid) begin
        idle();
        step();
        return;
      end
    end
    check("drain_timeout", 1, 0);
  endtask

  initial begin
    logic [XLEN-1:0] da, db;
    model_reset();
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ex_valid", ex_valid, 0);
    check("reset_dec_ready", dec_ready, 1);
    rst_n = 1'b1;

    // Basic issue: x3=5, x4=7 -> op1=5 op2=7, x5 becomes busy.
    idle(); issue(5'd3, 5'd4, 5'd5, 1'b1); step();
    check("basic_op1", ex_op1, 64'd5);
    check("basic_op2", ex_op2, 64'd7);

    // RAW on x5 stalls until wb1 returns 0x2A, which is bypassed in the same cycle.
    idle(); issue(5'd5, 5'd0, 5'd6, 1'b1);
    #1 check("raw_stall", dec_ready, 0);
    step();
    idle(); issue(5'd5, 5'd0, 5'd6, 1'b1); step();
    idle(); issue(5'd5, 5'd0, 5'd6, 1'b1);
    take(5'd5); wb1_valid = 1'b1; wb1_addr = 5'd5; wb1_data = 64'h2A;
    #1 check("raw_release", dec_ready, 1);
    step();
    check("bypass_op1", ex_op1, 64'h2A);

    // Execute back-pressure: outputs and read address held for three cycles.
    for (int i = 0; i < 3; i++) begin
      idle(); ex_ready = 1'b0; issue(5'd1, 5'd2, 5'd8, 1'b1); step();
      check("hold_rs1_addr", rs1_addr, 5'd5);
      check("hold_op1", ex_op1, 64'h2A);
      check("hold_dec_ready", dec_ready, 0);
    end
    idle(); issue(5'd1, 5'd2, 5'd8, 1'b1); step();
    check("release_rd", ex_rd, 5'd8);

    // x0 sources read zero, rd=x0 sets nothing, wb to x0 ignored.
    idle(); issue(5'd0, 5'd0, 5'd0, 1'b1);
    wb1_valid = 1'b1; wb1_addr = 5'd0; wb1_data = '1;
    step();
    check("x0_op1", ex_op1, 0);
    check("x0_op2", ex_op2, 0);
    drain();

    // Set beats a same-cycle clear of x7; the next writer of x7 hits WAW.
    idle(); issue(5'd0, 5'd0, 5'd7, 1'b1);
    wb2_valid = 1'b1; wb2_addr = 5'd7; wb2_data = 64'h77;
    step();
    idle(); issue(5'd0, 5'd0, 5'd7, 1'b1);
    #1 check("waw_stall", dec_ready, 0);
    step();
    drain();

    // wb1 takes priority over wb2 on the same address.
    idle(); issue(5'd0, 5'd0, 5'd9, 1'b1); step();
    idle(); step();
    da = {$urandom, $urandom}; db = ~da;
    idle(); issue(5'd9, 5'd9, 5'd0, 1'b0); take(5'd9);
    wb1_valid = 1'b1; wb1_addr = 5'd9; wb1_data = da;
    wb2_valid = 1'b1; wb2_addr = 5'd9; wb2_data = db;
    step();
    check("wb_prio_op1", ex_op1, da);
    check("wb_prio_op2", ex_op2, da);
    drain();

    // Randomized traffic over a small register window to provoke hazards.
    for (int c = 0; c < 1500; c++) begin
      idle();
      if ($urandom_range(3) != 0)
        issue(5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)),
              1'($urandom_range(1)));
      ex_ready = ($urandom_range(9) < 7);
      drive_wbs();
      step();
    end
    drain();

    // Reset in the middle of a stall: x10 in flight, execute stalled, consumer of x10 waiting.
    idle(); issue(5'd0, 5'd0, 5'd10, 1'b1); step();
    for (int i = 0; i < 3; i++) begin
      idle(); ex_ready = 1'b0; issue(5'd10, 5'd0, 5'd11, 1'b1); step();
    end
    #2 rst_n = 1'b0;
    #1;
    check("rst_ex_valid", ex_valid, 0);
`ifdef WARP_XISSUE_STALL_CNT_EN
    check("rst_stall_cnt", stall_cnt, 0);
`endif
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(); issue(5'd10, 5'd0, 5'd11, 1'b1);
    #1 check("rst_sb_clear", dec_ready, 1);
    step();
    idle(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
